// File: rtl/dch_pkg.sv
// Shared definitions for the down counter with clock control:
// default width, rate/underflow encodings and prescaler sizing.
package dch_pkg;

  localparam int DCH_WIDTH = 4;

  localparam logic DCH_MODE_WRAP   = 1'b0;
  localparam logic DCH_MODE_RELOAD = 1'b1;

  localparam logic DCH_SEL_FAST = 1'b0;
  localparam logic DCH_SEL_DIV  = 1'b1;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int dch_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((value - 1) >> i) != 0) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dch_prescaler.sv
// Step-rate generator: passes the enable straight through in fast mode,
// or divides enabled clocks by DIV in divided mode.
module dch_prescaler
  import dch_pkg::*;
#(
  parameter int DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sel,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = dch_clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d, base;
  logic          sel_q, sel_d;

  always_comb begin
    sel_d = sel;
    tick  = 1'b0;
    cnt_d = '0;
    // A rate change restarts the divide sequence on the edge that sees it.
    base  = (sel != sel_q) ? '0 : cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (sel == DCH_SEL_FAST) begin
      tick = en;
    end else if (en) begin
      if (base == LAST) tick = 1'b1;
      else              cnt_d = base + PW'(1);
    end else begin
      cnt_d = base;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sel_q <= DCH_SEL_FAST;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: rtl/dch.sv
// Down counter with selectable step rate, synchronous load, wrap/reload on
// underflow, zero flag and a registered terminal-count pulse.
module dch
  import dch_pkg::*;
#(
  parameter int WIDTH = DCH_WIDTH,
  parameter int DIV   = 100000000
) (
  input  logic             dch_clk,
  input  logic             dch_rst,
  input  logic             dch_en,
  input  logic             dch_sel,
  input  logic             dch_load,
  input  logic [WIDTH-1:0] dch_d,
  input  logic             dch_mode,
  output logic [WIDTH-1:0] dch_q,
  output logic             dch_zero,
  output logic             dch_tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             tick;

  dch_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (dch_clk),
    .rst  (dch_rst),
    .en   (dch_en),
    .sel  (dch_sel),
    .clr  (dch_load),
    .tick (tick)
  );

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    // Load wins over any coincident tick; the tick is simply dropped.
    if (dch_load) begin
      cnt_d = dch_d;
    end else if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        tc_d  = 1'b1;
        cnt_d = (dch_mode == DCH_MODE_RELOAD) ? dch_d : '1;
      end
    end
  end

  always_ff @(posedge dch_clk or negedge dch_rst) begin
    if (!dch_rst) begin
      cnt_q <= '1;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign dch_q    = cnt_q;
  assign dch_tc   = tc_q;
  assign dch_zero = (cnt_q == '0);

endmodule

// File: tb/tb_dch.sv
// Directed bench for dch with DIV=4: free-run, divided rate, pause,
// load/reload, asynchronous reset and the reload-of-zero corner.
module tb_dch;

  localparam int WIDTH = 4;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             sel;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             mode;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             tc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dch #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .dch_clk  (clk),
    .dch_rst  (rst_n),
    .dch_en   (en),
    .dch_sel  (sel),
    .dch_load (load),
    .dch_d    (d),
    .dch_mode (mode),
    .dch_q    (q),
    .dch_zero (zero),
    .dch_tc   (tc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sel = 1'b0; load = 1'b0; d = '0; mode = 1'b0;

    // 1. reset, then free-run at full rate with wrap
    step();
    check("rst_q", 32'(q), 32'hF);
    check("rst_tc", 32'(tc), 32'h0);
    check("rst_zero", 32'(zero), 32'h0);
    rst_n = 1'b1; en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("run_q%0d", i), 32'(q), 32'((15 - i) & 15));
      check($sformatf("run_zero%0d", i), 32'(zero), (i == 15) ? 32'h1 : 32'h0);
      check($sformatf("run_tc%0d", i), 32'(tc), (i == 16) ? 32'h1 : 32'h0);
    end

    // 2. divided rate from reset, then switch back to fast
    rst_n = 1'b0; step(); rst_n = 1'b1;
    sel = 1'b1; en = 1'b1;
    step(); step(); step();
    check("div_q3", 32'(q), 32'hF);
    step();
    check("div_q4", 32'(q), 32'hE);
    check("div_tc4", 32'(tc), 32'h0);
    step(); step(); step();
    check("div_q7", 32'(q), 32'hE);
    step();
    check("div_q8", 32'(q), 32'hD);
    sel = 1'b0;
    step();
    check("fast_q1", 32'(q), 32'hC);
    step();
    check("fast_q2", 32'(q), 32'hB);

    // 3. pause in divided mode with the prescaler at 2
    sel = 1'b1;
    step(); step();
    check("pause_pre", 32'(q), 32'hB);
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pause_hold", 32'(q), 32'hB);
    en = 1'b1;
    step();
    check("resume_1", 32'(q), 32'hB);
    step();
    check("resume_2", 32'(q), 32'hA);

    // 4. load, then reload-on-underflow at full rate
    sel = 1'b0; en = 1'b0; load = 1'b1; d = 4'd5;
    step();
    check("load_q", 32'(q), 32'h5);
    check("load_tc", 32'(tc), 32'h0);
    load = 1'b0; mode = 1'b1; en = 1'b1;
    step(); check("rl_q1", 32'(q), 32'h4);
    step(); check("rl_q2", 32'(q), 32'h3);
    step(); check("rl_q3", 32'(q), 32'h2);
    step(); check("rl_q4", 32'(q), 32'h1);
    step(); check("rl_q5", 32'(q), 32'h0);
    check("rl_zero5", 32'(zero), 32'h1);
    check("rl_tc5", 32'(tc), 32'h0);
    step(); check("rl_q6", 32'(q), 32'h5);
    check("rl_tc6", 32'(tc), 32'h1);
    step(); check("rl_q7", 32'(q), 32'h4);
    check("rl_tc7", 32'(tc), 32'h0);
    load = 1'b1; d = 4'd9;
    step();
    check("load_vs_tick", 32'(q), 32'h9);
    load = 1'b0;

    // 5. asynchronous reset between edges
    mode = 1'b0; en = 1'b0; load = 1'b1; d = 4'd7;
    step();
    load = 1'b0; sel = 1'b1; en = 1'b1;
    step(); step();
    check("pre_arst_q", 32'(q), 32'h7);
    #3 rst_n = 1'b0;
    #1;
    check("arst_q", 32'(q), 32'hF);
    check("arst_tc", 32'(tc), 32'h0);
    rst_n = 1'b1;
    step(); step(); step();
    check("arst_pre_q3", 32'(q), 32'hF);
    step();
    check("arst_pre_q4", 32'(q), 32'hE);

    sel = 1'b0; en = 1'b0; load = 1'b1; d = 4'd0;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check("tc_before_arst", 32'(tc), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_tc_clear", 32'(tc), 32'h0);
    check("arst_q_f", 32'(q), 32'hF);
    rst_n = 1'b1;

    // 6. reload value of zero: q pinned at 0, tc every tick
    en = 1'b0; mode = 1'b1; d = 4'd0; load = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("z_q%0d", i), 32'(q), 32'h0);
      check($sformatf("z_tc%0d", i), 32'(tc), 32'h1);
      check($sformatf("z_zero%0d", i), 32'(zero), 32'h1);
    end
    en = 1'b0;
    step();
    check("z_off_tc", 32'(tc), 32'h0);
    check("z_off_q", 32'(q), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
